// File: rtl/led_red_fx.sv
`default_nettype none
// ============================================================================
//  Module      : led_red_fx
//  Description : Red-LED pin driver with pass/blink/chase effects and PWM
//                dimming, configured over an Avalon-MM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_red_fx #(
   parameter int TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [17:0] pattern_in,
   output logic [17:0] led_o
);

   localparam int         c_PRE_W      = $clog2(TICK_DIV);
   localparam logic [1:0] c_MODE_PASS  = 2'd0;
   localparam logic [1:0] c_MODE_BLINK = 2'd1;
   localparam logic [1:0] c_MODE_LEFT  = 2'd2;
   localparam logic [1:0] c_MODE_RIGHT = 2'd3;

   logic [1:0]         r_mode;
   logic [3:0]         r_bright;
   logic               r_enable;
   logic [15:0]        r_rate;
   logic [c_PRE_W-1:0] r_pre;
   logic [15:0]        r_rc;
   logic [3:0]         r_pwm;
   logic               r_phase;
   logic [17:0]        r_rot;
   logic [17:0]        r_pat_q;

   logic        w_wr;
   logic        w_ctrl_wr;
   logic        w_rate_wr;
   logic        w_tick;
   logic        w_restart;
   logic        w_step;
   logic        w_gate;
   logic [17:0] w_sel;
   logic        w_unused_wdata;

   assign w_wr      = chipselect & ~write_n;
   assign w_ctrl_wr = w_wr & (address == 2'd0);
   assign w_rate_wr = w_wr & (address == 2'd1);
   assign w_tick    = (r_pre == c_PRE_W'(TICK_DIV - 1));
   assign w_restart = (pattern_in != r_pat_q) | (w_ctrl_wr & (writedata[1:0] != r_mode));
   // Restart and RATE writes both clear rc, so either one swallows a step.
   assign w_step    = w_tick & (r_rc == r_rate - 16'd1) & ~w_restart & ~w_rate_wr;
   assign w_gate    = (r_bright == 4'd15) | (r_pwm < r_bright);

   assign w_unused_wdata = ^{writedata[31:16], writedata[3:2]};

   always_comb begin
      w_sel = r_pat_q;
      case (r_mode)
         c_MODE_PASS  : w_sel = r_pat_q;
         c_MODE_BLINK : w_sel = r_phase ? r_pat_q : 18'd0;
         default      : w_sel = r_rot;
      endcase
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0    : readdata = {23'd0, r_enable, r_bright, 2'b00, r_mode};
         2'd1    : readdata = {16'd0, r_rate};
         2'd2    : readdata = {14'd0, led_o};
         default : readdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode   <= c_MODE_PASS;
         r_bright <= 4'd15;
         r_enable <= 1'b1;
         r_rate   <= 16'd250;
      end else begin
         if (w_ctrl_wr) begin
            r_mode   <= writedata[1:0];
            r_bright <= writedata[7:4];
            r_enable <= writedata[8];
         end
         if (w_rate_wr)
            r_rate <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre   <= '0;
         r_rc    <= 16'd0;
         r_pwm   <= 4'd0;
         r_pat_q <= 18'd0;
      end else begin
         r_pre   <= w_tick ? '0 : r_pre + 1'b1;
         r_pwm   <= r_pwm + 4'd1;
         r_pat_q <= pattern_in;
         if (w_restart || w_rate_wr)
            r_rc <= 16'd0;
         else if (w_tick)
            r_rc <= (r_rc == r_rate - 16'd1) ? 16'd0 : r_rc + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= 1'b1;
         r_rot   <= 18'd0;
      end else if (w_restart) begin
         r_phase <= 1'b1;
         r_rot   <= pattern_in;
      end else if (w_step) begin
         if (r_mode == c_MODE_BLINK)
            r_phase <= ~r_phase;
         if (r_mode == c_MODE_LEFT)
            r_rot <= {r_rot[16:0], r_rot[17]};
         else if (r_mode == c_MODE_RIGHT)
            r_rot <= {r_rot[0], r_rot[17:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         led_o <= 18'd0;
      else
         led_o <= (r_enable & w_gate) ? w_sel : 18'd0;
   end

endmodule
`default_nettype wire

// File: tb/tb_led_red_fx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_red_fx
//  Description : Self-checking bench for led_red_fx against a step-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_red_fx;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [17:0] pattern_in = 18'd0;
   logic [17:0] led_o;

   int err_cnt = 0;
   int chk_cnt = 0;

   // Model: output is the restart anchor rotated by the number of steps taken.
   int          m_cyc, m_ticks, m_nsteps, m_rate;
   logic [17:0] m_patq, m_anchor, m_led;
   logic [1:0]  m_mode;
   logic [3:0]  m_bright;
   logic        m_en;
   logic [17:0] cur_pat;

   led_red_fx #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .pattern_in(pattern_in), .led_o(led_o)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] rotl(input logic [17:0] x, input int k);
      logic [35:0] d;
      d = {x, x} << k;
      return d[35:18];
   endfunction

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {23'd0, m_en, m_bright, 2'b00, m_mode};
         2'd1:    return 32'(m_rate);
         2'd2:    return {14'd0, m_led};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_ticks = 0; m_nsteps = 0; m_rate = 250;
      m_patq = 0; m_anchor = 0; m_led = 0;
      m_mode = 0; m_bright = 15; m_en = 1;
   endtask

   task automatic model_edge(input logic [17:0] pin, input bit wr,
                             input logic [1:0] a, input logic [31:0] wd);
      bit tick, cw, rw, restart, clr, step, gate;
      logic [17:0] sel;
      tick    = (m_cyc % TD) == TD - 1;
      cw      = wr && a == 2'd0;
      rw      = wr && a == 2'd1;
      restart = (pin != m_patq) || (cw && wd[1:0] != m_mode);
      clr     = restart || rw;
      step    = tick && !clr && ((m_ticks + 1) % m_rate == 0);
      case (m_mode)
         2'd0:    sel = m_patq;
         2'd1:    sel = (m_nsteps % 2 == 0) ? m_patq : 18'd0;
         2'd2:    sel = rotl(m_anchor, m_nsteps % 18);
         default: sel = rotl(m_anchor, (18 - m_nsteps % 18) % 18);
      endcase
      gate  = (m_bright == 15) || ((m_cyc % 16) < int'(m_bright));
      m_led = (m_en && gate) ? sel : 18'd0;
      if (clr) m_ticks = 0;
      else if (tick) m_ticks++;
      if (restart) begin m_anchor = pin; m_nsteps = 0; end
      else if (step) m_nsteps++;
      if (cw) begin m_mode = wd[1:0]; m_bright = wd[7:4]; m_en = wd[8]; end
      if (rw) m_rate = (wd[15:0] == 0) ? 1 : int'(wd[15:0]);
      m_patq = pin;
      m_cyc++;
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit.
   task automatic cyc(input logic [17:0] pin, input bit wr,
                      input logic [1:0] a, input logic [31:0] wd);
      pattern_in = pin; chipselect = wr; write_n = ~wr; address = a; writedata = wd;
      @(posedge clk);
      model_edge(pin, wr, a, wd);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if (led_o !== 18'd0) begin err_cnt++; $display("FAIL reset_led: got %h want 0", led_o); end
      address = 2'd0; #1;
      chk_cnt++;
      if (readdata !== 32'h1F0) begin err_cnt++; $display("FAIL reset_ctrl: got %h want 1f0", readdata); end
      address = 2'd1; #1;
      chk_cnt++;
      if (readdata !== 32'd250) begin err_cnt++; $display("FAIL reset_rate: got %0d want 250", readdata); end
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_pass();
      cur_pat = 18'h2AAAA;
      cyc(cur_pat, 0, 2'd2, 0);
      chk_cnt++;
      if (led_o !== 18'd0) begin err_cnt++; $display("FAIL pass_lat1: got %h want 0", led_o); end
      cyc(cur_pat, 0, 2'd2, 0);
      chk_cnt++;
      if (led_o !== 18'h2AAAA) begin err_cnt++; $display("FAIL pass_lat2: got %h want 2aaaa", led_o); end
      chk_cnt++;
      if (readdata !== 32'h0002AAAA) begin err_cnt++; $display("FAIL pass_status: got %h want 2aaaa", readdata); end
   endtask

   task automatic test_blink();
      cur_pat = 18'h3FFFF;
      cyc(cur_pat, 1, 2'd1, 32'd3);
      cyc(cur_pat, 1, 2'd0, 32'h1F1);
      for (int i = 0; i < 90; i++) begin
         if (i == 37) cur_pat = 18'h15555;
         cyc(cur_pat, 0, 2'd2, 0);
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL blink[%0d]: got %h want %h", i, led_o, m_led); end
      end
   endtask

   task automatic test_chase();
      int n;
      cur_pat = 18'h00001;
      cyc(cur_pat, 1, 2'd1, 32'd1);
      cyc(cur_pat, 1, 2'd0, 32'h1F2);
      for (int i = 0; i < 80; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL chase_left[%0d]: got %h want %h", i, led_o, m_led); end
      end
      cyc(cur_pat, 1, 2'd0, 32'h1F3);
      n = 0;
      while (led_o !== 18'h00001 && n < 4) begin cyc(cur_pat, 0, 2'd0, 0); n++; end
      n = 0;
      while (led_o === 18'h00001 && n < 20) begin cyc(cur_pat, 0, 2'd0, 0); n++; end
      chk_cnt++;
      if (led_o !== 18'h20000) begin err_cnt++; $display("FAIL chase_right_first: got %h want 20000", led_o); end
   endtask

   task automatic test_rate_edge();
      cyc(cur_pat, 1, 2'd1, 32'd0);
      chk_cnt++;
      if (readdata !== 32'd1) begin err_cnt++; $display("FAIL rate_zero_read: got %0d want 1", readdata); end
      cyc(cur_pat, 1, 2'd0, 32'h1F2);
      for (int i = 0; i < 3; i++) begin
         while ((m_cyc % TD) != TD - 1) cyc(cur_pat, 0, 2'd1, 0);
         cyc(cur_pat, 1, 2'd1, 32'(i + 2));
         for (int j = 0; j < 24; j++) begin
            cyc(cur_pat, 0, 2'd1, 0);
            chk_cnt++;
            if (led_o !== m_led) begin err_cnt++; $display("FAIL rate_coincide[%0d]: got %h want %h", j, led_o, m_led); end
         end
      end
   endtask

   task automatic test_pwm();
      int ones;
      cur_pat = 18'h3FFFF;
      cyc(cur_pat, 1, 2'd0, 32'h140);
      repeat (3) cyc(cur_pat, 0, 2'd0, 0);
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         if (led_o === 18'h3FFFF) ones++;
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL pwm4[%0d]: got %h want %h", i, led_o, m_led); end
      end
      chk_cnt++;
      if (ones != 4) begin err_cnt++; $display("FAIL pwm4_duty: got %0d want 4", ones); end
      cyc(cur_pat, 1, 2'd0, 32'h100);
      for (int i = 0; i < 32; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         chk_cnt++;
         if (led_o !== 18'd0) begin err_cnt++; $display("FAIL pwm0[%0d]: got %h want 0", i, led_o); end
      end
   endtask

   task automatic test_enable_off();
      cur_pat = 18'h00003;
      cyc(cur_pat, 1, 2'd1, 32'd1);
      cyc(cur_pat, 1, 2'd0, 32'h0F2);
      for (int i = 0; i < 23; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         chk_cnt++;
         if (led_o !== 18'd0) begin err_cnt++; $display("FAIL disabled[%0d]: got %h want 0", i, led_o); end
      end
      cyc(cur_pat, 1, 2'd0, 32'h1F2);
      for (int i = 0; i < 24; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL reenabled[%0d]: got %h want %h", i, led_o, m_led); end
      end
   endtask

   task automatic test_random();
      logic [31:0] wd;
      bit          wr;
      logic [1:0]  a;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) cur_pat = 18'($urandom);
         wr = ($urandom_range(0, 24) == 0);
         a  = 2'($urandom_range(0, 3));
         wd = $urandom;
         if (a == 2'd1) wd[15:0] = 16'($urandom_range(0, 4));
         if (a == 2'd0 && $urandom_range(0, 3) != 0) wd[8] = 1'b1;
         cyc(cur_pat, wr, a, wd);
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL random_led[%0d]: got %h want %h", i, led_o, m_led); end
         chk_cnt++;
         if (readdata !== exp_rd(a)) begin err_cnt++; $display("FAIL random_rd[%0d] a=%0d: got %h want %h", i, a, readdata, exp_rd(a)); end
      end
   endtask

   task automatic test_reset_mid();
      cur_pat = 18'h0F0F0;
      cyc(cur_pat, 1, 2'd1, 32'd1);
      cyc(cur_pat, 1, 2'd0, 32'h1F2);
      repeat (9) cyc(cur_pat, 0, 2'd0, 0);
      #2 reset_n = 1'b0;
      #1;
      chk_cnt++;
      if (led_o !== 18'd0) begin err_cnt++; $display("FAIL reset_async_led: got %h want 0", led_o); end
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      #1;
      chk_cnt++;
      if (readdata !== 32'h1F0) begin err_cnt++; $display("FAIL reset_mid_ctrl: got %h want 1f0", readdata); end
      for (int i = 0; i < 8; i++) begin
         cyc(cur_pat, 0, 2'd0, 0);
         chk_cnt++;
         if (led_o !== m_led) begin err_cnt++; $display("FAIL after_reset[%0d]: got %h want %h", i, led_o, m_led); end
      end
   endtask

   initial begin
      model_reset();
      cur_pat = 18'd0;
      test_reset();
      test_pass();
      test_blink();
      test_chase();
      test_rate_edge();
      test_pwm();
      test_enable_off();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
